vc_circular_buffer: RTL
=======================

# vc_circular_buffer

Per-input-port flit buffer for the NoC router: a parametrised successor to the single-queue circular buffer, holding VC_NUM independent circular FIFOs of BUFFER_SIZE flits each in one storage array. Writes and reads each address one virtual channel per cycle. Each VC reports empty/full status and a hysteretic on/off credit signal for the upstream router. It sits between the link input and the router's route-compute/VC-allocation stage.

## Interface
- VC_NUM, 2, number of virtual channels (>=1)
- BUFFER_SIZE, 8, flits per VC (power of two, >=2)
- OFF_THRESHOLD, BUFFER_SIZE-2, occupancy at/above which buf_On_Off[v] drops
- ON_THRESHOLD, 1, occupancy at/below which buf_On_Off[v] rises (ON_THRESHOLD < OFF_THRESHOLD)

Ports (VW = max(1,$clog2(VC_NUM)), CW = $clog2(BUFFER_SIZE)+1):
- clk  in  1  single clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- write_i  in  1  write strobe
- write_vc_i  in  VW  target VC of write
- input_Data  in  flit_Data_noVC  flit to store (params_noc type)
- read_i  in  1  read (pop) strobe
- read_vc_i  in  VW  VC to read
- output_Data  out  flit_Data_noVC  head flit of read_vc_i (first-word fall-through)
- buf_empty  out  VC_NUM  per-VC empty
- buf_full  out  VC_NUM  per-VC full
- buf_On_Off  out  VC_NUM  1 = upstream may send on VC v
- vc_count  out  VC_NUM*CW  per-VC occupancy, VC v at [v*CW +: CW]
- err_overflow  out  VC_NUM  sticky write-on-full flag
- err_underflow  out  VC_NUM  sticky read-on-empty flag

## Operation
- Per VC: read pointer, write pointer (CW-1 bits, natural wrap at BUFFER_SIZE), count (CW bits). Storage index = v*BUFFER_SIZE + ptr.
- Write accepted when write_i and (count<BUFFER_SIZE, or read_i on same VC with count>0); stores flit, increments write pointer.
- Read accepted when read_i and count>0; increments read pointer. No bypass: a flit written this cycle is not readable this cycle.
- Same-VC write+read, both accepted: count unchanged. Different VCs: each updates independently.
- Write to full VC without same-VC read: dropped, storage/pointers unchanged, err_overflow[v] set. Read on empty VC: ignored, err_underflow[v] set.
- write_vc_i/read_vc_i >= VC_NUM: operation ignored, no flag.
- buf_On_Off[v]: clears when next count >= OFF_THRESHOLD; sets when next count <= ON_THRESHOLD; otherwise holds (hysteresis).
- output_Data is combinational mux of storage[read_vc_i, rdptr]; value undefined-but-stable (last stored) when that VC is empty.

## Timing
- Reset (rst=1 at edge): all pointers/counts 0, buf_empty all 1, buf_full all 0, buf_On_Off all 1, vc_count 0, err flags 0; storage not cleared. Reset mid-traffic discards all flits the same edge.
- Write at edge N: flit visible at output_Data and in vc_count/buf_empty after edge N; readable at edge N+1.
- buf_empty, buf_full, buf_On_Off, vc_count, err flags are registered; update on the edge that changes count.
- Throughput: one write and one read per cycle sustained.

## Configuration
- VCB_ERR_FLAGS_EN defined: err_overflow/err_underflow implemented as sticky registers, cleared only by rst.
- Not defined: both ports driven constant 0; drop/ignore behaviour on full/empty unchanged.

## Test plan
(VC_NUM=2, BUFFER_SIZE=4, OFF_THRESHOLD=3, ON_THRESHOLD=1, macro defined)
- Reset then idle -> buf_empty=2'b11, buf_full=2'b00, buf_On_Off=2'b11, counts 0.
- Write HEAD flits A,B,C,D to VC0 on consecutive cycles -> after C buf_On_Off[0]=0; after D buf_full[0]=1, count 4; VC1 untouched.
- Read VC0 four times -> output_Data A,B,C,D in order; buf_On_Off[0] stays 0 at count 2, returns 1 at count 1; buf_empty[0]=1 at end.
- VC0 full, write E with same-cycle read VC0 -> A popped, E stored, count stays 4, err_overflow[0]=0; E returned after B,C,D (wrap-around).
- Write to full VC1 alone and read empty VC0 -> flit dropped, err_overflow=2'b10, err_underflow=2'b01, counts unchanged; flags persist until rst.
- Assert rst with both VCs holding flits -> next cycle all counts 0, buf_empty=2'b11, err flags 0.

Source files
------------

// File: rtl/vc_circular_buffer.sv
// ---------------------------------------------------------------------------
// vc_circular_buffer
//
// Per-input-port flit buffer for the NoC router. Holds VC_NUM independent
// circular FIFOs of BUFFER_SIZE flits each, packed into one storage array
// (VC v occupies entries v*BUFFER_SIZE .. v*BUFFER_SIZE+BUFFER_SIZE-1).
// One write and one read per cycle, each addressed to a single VC.
// The head flit of read_vc_i is presented combinationally (first-word
// fall-through); a read strobe pops it on the next rising edge.
//
// Optional feature macro: VCB_ERR_FLAGS_EN
//   defined     -> err_overflow / err_underflow are sticky registers,
//                  cleared only by rst.
//   not defined -> both flag ports are tied to 0. Drop-on-full and
//                  ignore-on-empty behaviour is the same either way.
//
// Ports (VW = max(1,$clog2(VC_NUM)), CW = $clog2(BUFFER_SIZE)+1):
//   clk            clock, everything on the rising edge
//   rst            synchronous active-high reset
//   write_i        write strobe
//   write_vc_i     [VW]    VC targeted by the write
//   input_Data     flit to store
//   read_i         read (pop) strobe
//   read_vc_i      [VW]    VC to read / VC whose head is shown
//   output_Data    head flit of read_vc_i (stale when that VC is empty)
//   buf_empty      [VC_NUM] per-VC empty
//   buf_full       [VC_NUM] per-VC full
//   buf_On_Off     [VC_NUM] 1 = upstream may send on that VC (hysteretic)
//   vc_count       [VC_NUM*CW] per-VC occupancy, VC v at [v*CW +: CW]
//   err_overflow   [VC_NUM] sticky write-on-full flag
//   err_underflow  [VC_NUM] sticky read-on-empty flag
// ---------------------------------------------------------------------------

package params_noc;

  parameter int FLIT_DATA_WIDTH = 32;

  typedef enum logic [1:0] {
    HEAD     = 2'b00,
    BODY     = 2'b01,
    TAIL     = 2'b10,
    HEADTAIL = 2'b11
  } flit_label_t;

  // Flit as carried inside a router port, without its VC id.
  typedef struct packed {
    flit_label_t                flit_label;
    logic [FLIT_DATA_WIDTH-1:0] data;
  } flit_Data_noVC;

endpackage

module vc_circular_buffer
  import params_noc::*;
#(
  parameter int VC_NUM        = 2,
  parameter int BUFFER_SIZE   = 8,
  parameter int OFF_THRESHOLD = BUFFER_SIZE - 2,
  parameter int ON_THRESHOLD  = 1,
  localparam int VW = (VC_NUM > 1) ? $clog2(VC_NUM) : 1,
  localparam int CW = $clog2(BUFFER_SIZE) + 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 write_i,
  input  logic [VW-1:0]        write_vc_i,
  input  flit_Data_noVC        input_Data,
  input  logic                 read_i,
  input  logic [VW-1:0]        read_vc_i,
  output flit_Data_noVC        output_Data,
  output logic [VC_NUM-1:0]    buf_empty,
  output logic [VC_NUM-1:0]    buf_full,
  output logic [VC_NUM-1:0]    buf_On_Off,
  output logic [VC_NUM*CW-1:0] vc_count,
  output logic [VC_NUM-1:0]    err_overflow,
  output logic [VC_NUM-1:0]    err_underflow
);

  // Pointer width: BUFFER_SIZE is a power of two, so pointers wrap naturally.
  localparam int PW    = CW - 1;
  localparam int AW    = VW + PW;
  localparam int DEPTH = VC_NUM * BUFFER_SIZE;

  localparam logic [CW-1:0] FULL_CNT = CW'(BUFFER_SIZE);
  localparam logic [CW-1:0] OFF_CNT  = CW'(OFF_THRESHOLD);
  localparam logic [CW-1:0] ON_CNT   = CW'(ON_THRESHOLD);

  logic [PW-1:0]       rd_ptr     [VC_NUM];
  logic [PW-1:0]       wr_ptr     [VC_NUM];
  logic [CW-1:0]       count      [VC_NUM];
  logic [CW-1:0]       next_count [VC_NUM];

  logic [VC_NUM-1:0]   wr_sel;   // write addressed to this VC
  logic [VC_NUM-1:0]   rd_sel;   // read addressed to this VC
  logic [VC_NUM-1:0]   wr_ok;    // write accepted
  logic [VC_NUM-1:0]   rd_ok;    // read accepted

  logic                wr_en;
  logic [AW-1:0]       wr_addr;
  logic [AW-1:0]       rd_addr;

  flit_Data_noVC       mem [DEPTH];

  // -------------------------------------------------------------------------
  // Per-VC acceptance, next occupancy and storage addressing.
  // A VC index >= VC_NUM matches no v, so such operations fall through
  // untouched and raise no flag.
  // -------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal driven here gets a default first so no path leaves
    // it unassigned -- otherwise synthesis infers a latch.
    wr_sel  = '0;
    rd_sel  = '0;
    wr_ok   = '0;
    rd_ok   = '0;
    wr_en   = 1'b0;
    wr_addr = '0;
    rd_addr = '0;
    for (int v = 0; v < VC_NUM; v++) begin
      next_count[v] = count[v];

      wr_sel[v] = write_i && (write_vc_i == VW'(v));
      rd_sel[v] = read_i  && (read_vc_i  == VW'(v));

      rd_ok[v]  = rd_sel[v] && (count[v] != '0);
      // A full VC can still take a write when the same cycle pops it.
      wr_ok[v]  = wr_sel[v] && ((count[v] < FULL_CNT) || rd_ok[v]);

      unique case ({wr_ok[v], rd_ok[v]})
        2'b10:   next_count[v] = count[v] + CW'(1);
        2'b01:   next_count[v] = count[v] - CW'(1);
        default: next_count[v] = count[v];
      endcase

      if (wr_ok[v]) begin
        wr_en   = 1'b1;
        wr_addr = {VW'(v), wr_ptr[v]};
      end

      // Head-of-queue address follows read_vc_i regardless of read_i.
      if (read_vc_i == VW'(v)) begin
        rd_addr = {VW'(v), rd_ptr[v]};
      end
    end
  end

  // -------------------------------------------------------------------------
  // Pointers, occupancy and registered status.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values, independent of statement order.
    if (rst) begin
      for (int v = 0; v < VC_NUM; v++) begin
        rd_ptr[v] <= '0;
        wr_ptr[v] <= '0;
        count[v]  <= '0;
      end
      buf_empty  <= '1;
      buf_full   <= '0;
      buf_On_Off <= '1;
    end else begin
      for (int v = 0; v < VC_NUM; v++) begin
        if (rd_ok[v]) rd_ptr[v] <= rd_ptr[v] + PW'(1);
        if (wr_ok[v]) wr_ptr[v] <= wr_ptr[v] + PW'(1);
        count[v]     <= next_count[v];
        buf_empty[v] <= (next_count[v] == '0);
        buf_full[v]  <= (next_count[v] == FULL_CNT);
        // Hysteresis: between the two thresholds the credit level holds.
        if (next_count[v] >= OFF_CNT) begin
          buf_On_Off[v] <= 1'b0;
        end else if (next_count[v] <= ON_CNT) begin
          buf_On_Off[v] <= 1'b1;
        end
      end
    end
  end

  // -------------------------------------------------------------------------
  // Flit storage.
  // -------------------------------------------------------------------------
  // NOTE: the storage array is deliberately not reset; pointers and counts
  // define what is valid, and leaving it reset-free lets it map onto RAM.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= input_Data;
  end

  // First-word fall-through: a flit written at edge N shows here after N.
  assign output_Data = mem[rd_addr];

  always_comb begin
    vc_count = '0;
    for (int v = 0; v < VC_NUM; v++) begin
      vc_count[v*CW +: CW] = count[v];
    end
  end

  // -------------------------------------------------------------------------
  // Error flags.
  // -------------------------------------------------------------------------
`ifdef VCB_ERR_FLAGS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      err_overflow  <= '0;
      err_underflow <= '0;
    end else begin
      // Rejected write = addressed but not accepted (full, no same-VC pop).
      err_overflow  <= err_overflow  | (wr_sel & ~wr_ok);
      err_underflow <= err_underflow | (rd_sel & ~rd_ok);
    end
  end
`else
  assign err_overflow  = '0;
  assign err_underflow = '0;
`endif

endmodule
